// File: rtl/avalonmm_arbiter_if.sv
// Command/status bundle between the two raw Avalon-MM masters, the shared slave
// and the arbiter that sequences ownership of the multiplexer.
interface avalonmm_arbiter_if;
  logic avalonm0_read;
  logic avalonm0_write;
  logic avalonm1_read;
  logic avalonm1_write;
  logic avalonm_out_waitrequest;
  logic avalonm_out_readdatavalid;
  logic select;
  logic stall0;
  logic stall1;
  logic pend_err;

  // Arbiter side: consumes strobes and slave status, produces mux controls.
  modport slave (
    input  avalonm0_read,
    input  avalonm0_write,
    input  avalonm1_read,
    input  avalonm1_write,
    input  avalonm_out_waitrequest,
    input  avalonm_out_readdatavalid,
    output select,
    output stall0,
    output stall1,
    output pend_err
  );

  // Environment side: masters and slave driving strobes, observing the controls.
  modport master (
    output avalonm0_read,
    output avalonm0_write,
    output avalonm1_read,
    output avalonm1_write,
    output avalonm_out_waitrequest,
    output avalonm_out_readdatavalid,
    input  select,
    input  stall0,
    input  stall1,
    input  pend_err
  );
endinterface

// File: rtl/avalonmm_arbiter.sv
// Round-robin, quantum-limited ownership sequencer for a two-master Avalon-MM mux.
// Ownership only moves at command boundaries and after all reads of the old owner return.
module avalonmm_arbiter #(
  parameter int unsigned QUANTUM = 16,
  parameter int unsigned PEND_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  avalonmm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0]        QMAX     = 8'(QUANTUM);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_select;
  logic              r_last;
  logic              r_stall0;
  logic              r_stall1;
  logic              r_pend_err;
  logic [7:0]        r_qcnt;
  logic [PEND_W-1:0] r_pend;

  logic [1:0]        w_rd;
  logic [1:0]        w_wr;
  logic [1:0]        w_req;
  logic              w_req_own;
  logic              w_req_oth;
  logic              w_rd_own;
  logic              w_stall_own;
  logic              w_acc;
  logic              w_rd_acc;
  logic [7:0]        w_qcnt_inc;
  logic [7:0]        w_qcnt_eff;
  logic [PEND_W-1:0] w_pend_next;
  logic              w_pend_err_next;
  logic              w_grant;
  logic              w_grant_to;

  assign w_rd = {bus.avalonm1_read,  bus.avalonm0_read};
  assign w_wr = {bus.avalonm1_write, bus.avalonm0_write};

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign w_req[gi] = w_rd[gi] | w_wr[gi];
  end

  // The owner is whoever the mux currently selects, even while draining.
  assign w_req_own   = w_req[r_select];
  assign w_req_oth   = w_req[~r_select];
  assign w_rd_own    = w_rd[r_select];
  assign w_stall_own = r_select ? r_stall1 : r_stall0;
  assign w_acc       = w_req_own & ~bus.avalonm_out_waitrequest & ~w_stall_own;
  assign w_rd_acc    = w_acc & w_rd_own;

  assign w_qcnt_inc = (r_qcnt >= QMAX) ? r_qcnt : r_qcnt + 8'd1;
  assign w_qcnt_eff = w_acc ? w_qcnt_inc : r_qcnt;

  // Outstanding-read tracking; misuse saturates the count and latches the error.
  always_comb begin
    w_pend_next     = r_pend;
    w_pend_err_next = r_pend_err;
    case ({w_rd_acc, bus.avalonm_out_readdatavalid})
      2'b10: begin
        if (r_pend == PEND_MAX) w_pend_err_next = 1'b1;
        else                    w_pend_next     = r_pend + 1'b1;
      end
      2'b01: begin
        if (r_pend == '0) w_pend_err_next = 1'b1;
        else              w_pend_next     = r_pend - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_to   = r_select;
    case (r_state)
      IDLE: begin
        // With both requesting, the master that was not granted last wins.
        if (w_req[0] && (!w_req[1] || r_last)) begin
          w_grant    = 1'b1;
          w_grant_to = 1'b0;
        end else if (w_req[1]) begin
          w_grant    = 1'b1;
          w_grant_to = 1'b1;
        end
      end
      OWN0, OWN1: begin
        // An acceptance is required unless the owner is idle, so a command
        // held under waitrequest can never be cut.
        if (w_req_oth && (!w_req_own || (w_acc && (w_qcnt_eff >= QMAX))))
          w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_pend_next == '0) begin
          w_grant    = 1'b1;
          w_grant_to = ~r_select;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_grant) w_state_next = w_grant_to ? OWN1 : OWN0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_select   <= 1'b0;
      r_last     <= 1'b1;
      r_stall0   <= 1'b1;
      r_stall1   <= 1'b1;
      r_qcnt     <= 8'd0;
      r_pend     <= '0;
      r_pend_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_stall0   <= (w_state_next != OWN0);
      r_stall1   <= (w_state_next != OWN1);
      r_pend     <= w_pend_next;
      r_pend_err <= w_pend_err_next;
      if (w_grant) begin
        r_select <= w_grant_to;
        r_last   <= w_grant_to;
        r_qcnt   <= 8'd0;
      end else begin
        r_qcnt   <= w_qcnt_eff;
      end
    end
  end

  assign bus.select   = r_select;
  assign bus.stall0   = r_stall0;
  assign bus.stall1   = r_stall1;
  assign bus.pend_err = r_pend_err;

endmodule
